// File: rtl/mod_pkg.sv
// Shared definitions for the mod_dp remainder datapath and its mod_cu controller.
package mod_pkg;

  localparam int W = 32;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    COMP  = 4'd2,
    CHECK = 4'd3,
    SUB   = 4'd4,
    ASSGN = 4'd5,
    DONE  = 4'd6,
    FIN   = 4'd7,
    ERR   = 4'd8
  } state_t;

endpackage

// File: rtl/mod_cu.sv
// Control unit for mod_dp: sequences load/compare/subtract/writeback for a mod b,
// bounds the subtraction count and reports divide-by-zero or timeout through err.
module mod_cu #(
  parameter int W        = mod_pkg::W,
  parameter int CNT_W    = 10,
  parameter int MAX_ITER = 1000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     bin,
  input  logic             less_than,
  output logic             isAssgn,
  output logic             isComp,
  output logic             isSub,
  output logic             assgn,
  output logic             isDone,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);
  import mod_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] iter_cnt_reg, iter_cnt_next;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      iter_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      iter_cnt_reg <= iter_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    iter_cnt_next = iter_cnt_reg;
    // abort also outranks start while idle, so one test covers every state
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (bin == '0) begin
              state_next = ERR;
            end else begin
              iter_cnt_next = '0;
              state_next    = LOAD;
            end
          end
        end
        LOAD:  state_next = COMP;
        COMP:  state_next = CHECK;
        CHECK: begin
          // the limit is tested before SUB, so the counter can never wrap
          if (less_than)                   state_next = DONE;
          else if (iter_cnt_reg == MAX_CNT) state_next = ERR;
          else                             state_next = SUB;
        end
        SUB: begin
          iter_cnt_next = iter_cnt_reg + CNT_W'(1);
          state_next    = ASSGN;
        end
        ASSGN:   state_next = COMP;
        DONE:    state_next = FIN;
        FIN:     state_next = IDLE;
        ERR:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign isAssgn  = (state_reg == LOAD);
  assign isComp   = (state_reg == COMP);
  assign isSub    = (state_reg == SUB);
  assign assgn    = (state_reg == ASSGN);
  assign isDone   = (state_reg == DONE);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == FIN) || (state_reg == ERR);
  assign err      = (state_reg == ERR);
  assign iter_cnt = iter_cnt_reg;

endmodule

// File: tb/tb_mod_cu.sv
// Randomized scoreboard bench for mod_cu driving a behavioural remainder datapath.
module tb_mod_cu;

  localparam int W     = 32;
  localparam int CNT_W = 10;
  localparam int MAXI  = 6;

  logic             CLK = 1'b0;
  logic             RST_N, start, abort, less_than;
  logic [W-1:0]     ain, bin;
  logic             isAssgn, isComp, isSub, assgn, isDone, busy, done, err;
  logic [CNT_W-1:0] iter_cnt;

  mod_cu #(.W(W), .CNT_W(CNT_W), .MAX_ITER(MAXI)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .bin(bin),
    .less_than(less_than), .isAssgn(isAssgn), .isComp(isComp), .isSub(isSub),
    .assgn(assgn), .isDone(isDone), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  always #5 CLK = ~CLK;

  // behavioural datapath reacting to the controller's strobes
  logic [W-1:0] a_reg = '0, diff_reg = '0, res_reg = '0;
  logic         lt_reg = 1'b0;
  always @(posedge CLK) begin
    if (isAssgn) a_reg    <= ain;
    if (isComp)  lt_reg   <= (a_reg < bin);
    if (isSub)   diff_reg <= a_reg - bin;
    if (assgn)   a_reg    <= diff_reg;
    if (isDone)  res_reg  <= a_reg;
  end
  assign less_than = lt_reg;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int start_cyc;
    int lat;
    bit err;
    int iter;
    int subs;
    int res;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  exp_t sb[$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_iter = 0;

  task automatic compare(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_chk(input string nm, input int act, input int exp);
    chk_t c;
    c.name = nm;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // monitor: pops an expectation whenever done pulses
  int sub_seen = 0, isdone_seen = 0;
  initial begin
    exp_t e;
    chk_t c;
    forever begin
      @(negedge CLK);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        compare(c.name, c.act, c.exp);
      end
      if (!RST_N) begin
        sub_seen = 0;
        isdone_seen = 0;
      end else begin
        compare("ctrl_onehot", int'($countones({isAssgn, isComp, isSub, assgn, isDone}) <= 1), 1);
        if (isSub)  sub_seen++;
        if (isDone) isdone_seen++;
        if (err && !done) compare("err_without_done", 1, 0);
        if (done) begin
          if (sb.size() == 0) begin
            compare("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            compare("latency",    cyc - e.start_cyc + 1, e.lat);
            compare("err",        int'(err), int'(e.err));
            compare("iter_cnt",   int'(iter_cnt), e.iter);
            compare("sub_pulses", sub_seen, e.subs);
            compare("isDone_cnt", isdone_seen, e.err ? 0 : 1);
            if (!e.err) compare("remainder", int'(res_reg), e.res);
            $display("op start_cyc=%0d lat=%0d err=%0b iter=%0d res=%0d", e.start_cyc, e.lat, e.err, e.iter, res_reg);
          end
          sub_seen = 0;
          isdone_seen = 0;
        end else if (!busy) begin
          sub_seen = 0;
          isdone_seen = 0;
        end
      end
    end
  end

  // reference: remainder by repeated subtraction, capped at MAXI subtractions
  function automatic exp_t ref_model(input int a, input int b, input int sc);
    exp_t e;
    int k;
    e.start_cyc = sc;
    e.res = 0;
    if (b == 0) begin
      e.err = 1; e.lat = 1; e.iter = model_iter; e.subs = 0;
    end else begin
      k = a / b;
      if (k > MAXI) begin
        e.err = 1; e.lat = 4 * MAXI + 4; e.iter = MAXI; e.subs = MAXI;
      end else begin
        e.err = 0; e.lat = 4 * k + 5; e.iter = k; e.subs = k; e.res = a % b;
      end
    end
    return e;
  endfunction

  task automatic wait_idle(input int budget, input bit noise);
    bit idle_seen;
    idle_seen = 0;
    for (int i = 0; i < budget && !idle_seen; i++) begin
      @(negedge CLK);
      if (!busy) idle_seen = 1;
      start = noise && busy && i[0];
    end
    start = 1'b0;
    if (!idle_seen) push_chk("wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic run_op(input int a, input int b, input bit noise);
    exp_t e;
    @(negedge CLK);
    ain = W'(a);
    bin = W'(b);
    start = 1'b1;
    e = ref_model(a, b, cyc + 1);
    model_iter = e.iter;
    sb.push_back(e);
    @(posedge CLK);
    #1 start = 1'b0;
    wait_idle(4 * MAXI + 20, noise);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    RST_N = 1'b0; start = 1'b0; abort = 1'b0; ain = '0; bin = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    push_chk("rst_busy", int'(busy), 0);
    push_chk("rst_done_err", int'({done, err}), 0);
    push_chk("rst_ctrl", int'({isAssgn, isComp, isSub, assgn, isDone}), 0);
    push_chk("rst_iter", int'(iter_cnt), 0);
    RST_N = 1'b1;

    run_op(10, 3, 0);
    run_op(2, 5, 0);
    run_op(7, 0, 0);
    run_op(100, 1, 0);
    run_op(12, 2, 0);
    run_op(17, 4, 1);

    for (int n = 0; n < 40; n++) begin
      int a, b;
      a = int'($urandom_range(0, 63));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      run_op(a, b, $urandom_range(0, 3) == 0);
    end

    // abort sampled in the 6th cycle (second COMP) after the start edge
    @(negedge CLK);
    ain = 10; bin = 3; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (6) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    push_chk("abort_busy", int'(busy), 0);
    push_chk("abort_done", int'(done), 0);
    push_chk("abort_iter", int'(iter_cnt), 1);
    model_iter = 1;

    // abort outranks start in IDLE
    @(negedge CLK);
    start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    push_chk("idle_abort_busy", int'(busy), 0);
    push_chk("idle_abort_iter", int'(iter_cnt), 1);
    run_op(9, 0, 0);

    // reset during ASSGN with start held through reset
    @(negedge CLK);
    ain = 10; bin = 3; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (assgn) found = 1;
    end
    push_chk("reach_assgn", int'(found), 1);
    RST_N = 1'b0; start = 1'b1;
    @(negedge CLK);
    push_chk("rst2_busy", int'(busy), 0);
    push_chk("rst2_iter", int'(iter_cnt), 0);
    push_chk("rst2_outs", int'({isAssgn, isComp, isSub, assgn, isDone, done, err}), 0);
    repeat (2) @(negedge CLK);
    push_chk("rst2_hold_busy", int'(busy), 0);
    model_iter = 0;
    begin
      exp_t e;
      RST_N = 1'b1;
      e = ref_model(10, 3, cyc + 1);
      model_iter = e.iter;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    push_chk("start_after_rst", int'(busy), 1);
    wait_idle(4 * MAXI + 20, 0);

    repeat (2) @(negedge CLK);
    push_chk("sb_empty", sb.size(), 0);
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
